// File: rtl/ram_dp_stream_reader.sv
// Burst read client for RAM_DP: issues reads under a credit limit and streams words out of a small buffer.
// Build option RAM_DP_READER_STRIDE_EN adds stride_i, the per-read address step captured with start_i.
module ram_dp_stream_reader #(
   parameter int unsigned AddrWidth   = 16,
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned ReadLatency = 1,
   parameter int unsigned LenWidth    = AddrWidth + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [LenWidth-1:0]  len_i,
`ifdef RAM_DP_READER_STRIDE_EN
   input  logic [AddrWidth-1:0] stride_i,
`endif
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ram_rd_en_o,
   output logic [AddrWidth-1:0] ram_addr_r_o,
   input  logic [DataWidth-1:0] ram_data_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i
);

   localparam int unsigned Depth    = ReadLatency + 1;
   localparam int unsigned PtrWidth = $clog2(Depth);
   localparam int unsigned CntWidth = $clog2(Depth + 1);
   localparam int unsigned SumWidth = CntWidth + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e               state_q;
   state_e               state_d;

   logic [ReadLatency-1:0] vld_pipe_q;
   logic [AddrWidth-1:0]   next_addr_q;
   logic [AddrWidth-1:0]   last_addr_q;
   logic [LenWidth-1:0]    issue_rem_q;
   logic [LenWidth-1:0]    beat_rem_q;
   logic [DataWidth-1:0]   buf_q [Depth];
   logic [PtrWidth-1:0]    wr_ptr_q;
   logic [PtrWidth-1:0]    rd_ptr_q;
   logic [CntWidth-1:0]    occ_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   accept_c;
   logic                   zero_start_c;
   logic                   issue_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   last_beat_c;
   logic [CntWidth-1:0]    inflight_c;
   logic [SumWidth-1:0]    committed_c;
   logic [AddrWidth-1:0]   stride_start;
   logic [AddrWidth-1:0]   stride_w;

`ifdef RAM_DP_READER_STRIDE_EN
   logic [AddrWidth-1:0]   stride_q;

   // Stride is frozen for the whole burst once the command is accepted
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stride_q <= '0;
      end else if (accept_c) begin
         stride_q <= stride_i;
      end
   end

   assign stride_start = stride_i;
   assign stride_w     = stride_q;
`else
   assign stride_start = AddrWidth'(1);
   assign stride_w     = AddrWidth'(1);
`endif

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   // Handshake and credit: a read may issue only if every word already committed still fits the buffer
   always_comb begin
      inflight_c = '0;
      for (int i = 0; i < int'(ReadLatency); i++) begin
         inflight_c = inflight_c + CntWidth'(vld_pipe_q[i]);
      end
      pop_c        = (occ_q != '0) && ready_i;
      push_c       = vld_pipe_q[ReadLatency-1];
      committed_c  = SumWidth'(inflight_c) + SumWidth'(occ_q) - SumWidth'(pop_c);
      accept_c     = (state_q == IDLE) && start_i && (len_i != '0);
      zero_start_c = (state_q == IDLE) && start_i && (len_i == '0);
      issue_c      = accept_c ||
                     ((state_q == READ) && (issue_rem_q != '0) &&
                      (committed_c < SumWidth'(Depth)));
      last_beat_c  = pop_c && (beat_rem_q == LenWidth'(1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = READ;
            end
         end
         READ: begin
            if ((issue_rem_q == '0) || (issue_c && (issue_rem_q == LenWidth'(1)))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_beat_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The first read goes out in the accept cycle; the address bus only moves when a read issues
   always_comb begin
      ram_rd_en_o  = issue_c;
      ram_addr_r_o = last_addr_q;
      if (accept_c) begin
         ram_addr_r_o = base_addr_i;
      end else if (issue_c) begin
         ram_addr_r_o = next_addr_q;
      end
      valid_o = (occ_q != '0);
      data_o  = buf_q[rd_ptr_q];
      busy_o  = busy_q;
      done_o  = done_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_pipe_q  <= '0;
         next_addr_q <= '0;
         last_addr_q <= '0;
         issue_rem_q <= '0;
         beat_rem_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < int'(Depth); i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;

         if (accept_c) begin
            busy_q      <= 1'b1;
            last_addr_q <= base_addr_i;
            next_addr_q <= base_addr_i + stride_start;
            issue_rem_q <= len_i - LenWidth'(1);
            beat_rem_q  <= len_i;
         end else if (issue_c) begin
            last_addr_q <= next_addr_q;
            next_addr_q <= next_addr_q + stride_w;
            issue_rem_q <= issue_rem_q - LenWidth'(1);
         end

         if (zero_start_c) begin
            done_q <= 1'b1;
         end

         // Tracks which RAM cycles carry data owed to this burst
         vld_pipe_q[0] <= issue_c;
         for (int i = 1; i < int'(ReadLatency); i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
         end

         if (push_c) begin
            buf_q[wr_ptr_q] <= ram_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end

         if (pop_c) begin
            rd_ptr_q   <= ptr_inc(rd_ptr_q);
            beat_rem_q <= beat_rem_q - LenWidth'(1);
         end

         if (last_beat_c) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end

         occ_q <= occ_q + CntWidth'(push_c) - CntWidth'(pop_c);
      end
   end

endmodule

// File: tb/tb_ram_dp_stream_reader.sv
// Directed bench for ram_dp_stream_reader: one instance per read latency (1 and 2) driven in parallel.
module tb_ram_dp_stream_reader;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ready;
   logic [AW-1:0] base;
   logic [LW-1:0] len;
`ifdef RAM_DP_READER_STRIDE_EN
   logic [AW-1:0] stride;
`endif

   logic          busy1, done1, rd_en1, valid1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] ram_data1, data1;
   logic          busy2, done2, rd_en2, valid2;
   logic [AW-1:0] addr2;
   logic [DW-1:0] ram_data2, data2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_dp_stream_reader #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(1)) u_rl1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
`ifdef RAM_DP_READER_STRIDE_EN
      .stride_i(stride),
`endif
      .busy_o(busy1), .done_o(done1), .ram_rd_en_o(rd_en1), .ram_addr_r_o(addr1),
      .ram_data_i(ram_data1), .data_o(data1), .valid_o(valid1), .ready_i(ready)
   );

   ram_dp_stream_reader #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(2)) u_rl2 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
`ifdef RAM_DP_READER_STRIDE_EN
      .stride_i(stride),
`endif
      .busy_o(busy2), .done_o(done2), .ram_rd_en_o(rd_en2), .ram_addr_r_o(addr2),
      .ram_data_i(ram_data2), .data_o(data2), .valid_o(valid2), .ready_i(ready)
   );

   // RAM models with mem[a] = a
   logic [DW-1:0] r1_q, r2a_q, r2b_q;
   always @(posedge clk) begin
      if (rd_en1) r1_q <= DW'(addr1);
      if (rd_en2) r2a_q <= DW'(addr2);
      r2b_q <= r2a_q;
   end
   assign ram_data1 = r1_q;
   assign ram_data2 = r2b_q;

   logic [AW-1:0] aq1[$], aq2[$];
   logic [DW-1:0] q1[$], q2[$];
   int  out1, out2, ovf1, ovf2, unst1, unst2, dn1, dn2;
   bit  st1, st2;
   logic [DW-1:0] h1, h2;

   // Passive observers: address log, beat log, outstanding-word bound, stall stability
   always @(negedge clk) begin
      if (rst) begin
         out1 = 0; out2 = 0; st1 = 1'b0; st2 = 1'b0;
      end else begin
         if (rd_en1) aq1.push_back(addr1);
         if (rd_en2) aq2.push_back(addr2);
         if (valid1 && ready) q1.push_back(data1);
         if (valid2 && ready) q2.push_back(data2);
         if (st1 && !(valid1 === 1'b1 && data1 === h1)) unst1++;
         if (st2 && !(valid2 === 1'b1 && data2 === h2)) unst2++;
         st1 = valid1 && !ready; h1 = data1;
         st2 = valid2 && !ready; h2 = data2;
         out1 += int'(rd_en1) - int'(valid1 && ready);
         out2 += int'(rd_en2) - int'(valid2 && ready);
         if (out1 > 2) ovf1++;
         if (out2 > 3) ovf2++;
         if (done1) dn1++;
         if (done2) dn2++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_logs();
      aq1.delete(); aq2.delete(); q1.delete(); q2.delete();
      ovf1 = 0; ovf2 = 0; unst1 = 0; unst2 = 0; dn1 = 0; dn2 = 0;
   endtask

   task automatic wait_idle(input string tag, input logic [15:0] pat);
      int n;
      n = 0;
      while ((busy1 || busy2) && n < 500) begin
         next();
         ready = pat[n % 16];
         n++;
      end
      chk(tag, 32'(n < 500), 32'd1);
      ready = 1'b1;
      repeat (3) next();
   endtask

   task automatic chk_seq(input string tag, input int which, input logic [31:0] exp0,
                          input logic [31:0] step, input int cnt);
      int sz;
      logic [31:0] v;
      sz = (which == 1) ? q1.size() : (which == 2) ? q2.size() :
           (which == 3) ? aq1.size() : aq2.size();
      chk($sformatf("%s_count", tag), 32'(sz), 32'(cnt));
      for (int i = 0; i < cnt; i++) begin
         v = 'x;
         if (i < sz) begin
            case (which)
               1:       v = q1[i];
               2:       v = q2[i];
               3:       v = 32'(aq1[i]);
               default: v = 32'(aq2[i]);
            endcase
         end
         chk($sformatf("%s_%0d", tag, i), v, (exp0 + step * 32'(i)) & 32'h0000_FFFF);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b1;
`ifdef RAM_DP_READER_STRIDE_EN
      stride = 16'd1;
`endif
      clear_logs();
      next(); next();
      smp();
      chk("rst_busy", busy1, 0);     chk("rst_done", done1, 0);
      chk("rst_rd_en", rd_en1, 0);   chk("rst_addr", addr1, 0);
      chk("rst_valid", valid1, 0);   chk("rst_data", data1, 0);
      chk("rst_valid_rl2", valid2, 0);
      next();
      rst = 1'b0;
      next();

      // Test 1: base 0x10, len 4, ready high, cycle-exact timing
      clear_logs();
      start = 1'b1; base = 16'h0010; len = 17'd4;
      smp();
      chk("t1_rd_en_a0", rd_en1, 1); chk("t1_addr_a0", addr1, 32'h10); chk("t1_busy_a0", busy1, 0);
      next(); start = 1'b0;
      smp();
      chk("t1_busy_a1", busy1, 1); chk("t1_valid_a1", valid1, 0); chk("t1_addr_a1", addr1, 32'h11);
      next(); smp();
      chk("t1_valid_a2", valid1, 1); chk("t1_data_a2", data1, 32'h10); chk("t1_valid_rl2_a2", valid2, 0);
      next(); smp();
      chk("t1_data_a3", data1, 32'h11); chk("t1_valid_rl2_a3", valid2, 1); chk("t1_data_rl2_a3", data2, 32'h10);
      next(); smp();
      chk("t1_data_a4", data1, 32'h12);
      next(); smp();
      chk("t1_data_a5", data1, 32'h13); chk("t1_done_a5", done1, 0);
      next(); smp();
      chk("t1_done_a6", done1, 1); chk("t1_busy_a6", busy1, 0); chk("t1_valid_a6", valid1, 0);
      chk("t1_data_rl2_a6", data2, 32'h13); chk("t1_done_rl2_a6", done2, 0);
      next(); smp();
      chk("t1_done_a7", done1, 0); chk("t1_done_rl2_a7", done2, 1);
      next(); next();
      chk_seq("t1_beats_rl1", 1, 32'h10, 1, 4);
      chk_seq("t1_beats_rl2", 2, 32'h10, 1, 4);

      // Test 2: len 8 under irregular back-pressure
      clear_logs();
      start = 1'b1; base = 16'h0040; len = 17'd8;
      next(); start = 1'b0;
      wait_idle("t2_timeout", 16'b1001_1100_0110_1001);
      chk_seq("t2_beats_rl1", 1, 32'h40, 1, 8);
      chk_seq("t2_beats_rl2", 2, 32'h40, 1, 8);
      chk("t2_overfill_rl1", 32'(ovf1), 0); chk("t2_overfill_rl2", 32'(ovf2), 0);
      chk("t2_unstable_rl1", 32'(unst1), 0); chk("t2_unstable_rl2", 32'(unst2), 0);
      chk("t2_done_cnt", 32'(dn1), 1);

      // Test 3: burst wrapping past the top of memory
      clear_logs();
      start = 1'b1; base = 16'hFFFE; len = 17'd4;
      next(); start = 1'b0;
      wait_idle("t3_timeout", 16'hFFFF);
      chk_seq("t3_addr_rl1", 3, 32'hFFFE, 1, 4);
      chk_seq("t3_addr_rl2", 4, 32'hFFFE, 1, 4);
      chk_seq("t3_beats_rl1", 1, 32'hFFFE, 1, 4);

      // Test 4: zero-length command, then a start during a busy burst
      clear_logs();
      start = 1'b1; base = 16'h0077; len = 17'd0;
      smp();
      chk("t4_rd_en_zero", rd_en1, 0); chk("t4_rd_en_zero_rl2", rd_en2, 0);
      next(); start = 1'b0;
      smp();
      chk("t4_done_zero", done1, 1); chk("t4_done_zero_rl2", done2, 1);
      chk("t4_busy_zero", busy1, 0); chk("t4_rd_en_after", rd_en1, 0);
      next(); smp();
      chk("t4_done_clear", done1, 0); chk("t4_no_reads", 32'(aq1.size()), 0);
      next();
      clear_logs();
      start = 1'b1; base = 16'h0200; len = 17'd16;
      next(); start = 1'b0;
      next(); next();
      start = 1'b1; base = 16'h0300; len = 17'd5;
      next(); start = 1'b0;
      wait_idle("t4_timeout", 16'hFFFF);
      chk_seq("t4_beats_rl1", 1, 32'h200, 1, 16);
      chk("t4_count_rl2", 32'(q2.size()), 16);
      chk("t4_done_cnt_rl1", 32'(dn1), 1); chk("t4_done_cnt_rl2", 32'(dn2), 1);

      // Test 5: asynchronous reset during the third beat, then a fresh burst
      clear_logs();
      start = 1'b1; base = 16'h0500; len = 17'd10;
      next(); start = 1'b0;
      next(); next(); next();
      smp();
      chk("t5_third_valid", valid1, 1); chk("t5_third_data", data1, 32'h502);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_busy", busy1, 0);  chk("t5_rst_valid", valid1, 0);
      chk("t5_rst_data", data1, 0);  chk("t5_rst_rd_en", rd_en1, 0);
      chk("t5_rst_addr", addr1, 0);  chk("t5_rst_valid_rl2", valid2, 0);
      chk("t5_rst_busy_rl2", busy2, 0);
      next(); smp();
      chk("t5_no_done", done1, 0); chk("t5_no_done_rl2", done2, 0);
      next();
      rst = 1'b0;
      clear_logs();
      next();
      start = 1'b1; base = 16'h0100; len = 17'd2;
      next(); start = 1'b0;
      wait_idle("t5_timeout", 16'hFFFF);
      chk_seq("t5_beats_rl1", 1, 32'h100, 1, 2);
      chk_seq("t5_beats_rl2", 2, 32'h100, 1, 2);

`ifdef RAM_DP_READER_STRIDE_EN
      // Test 6: stride 3 from base 0
      clear_logs();
      start = 1'b1; base = 16'h0000; len = 17'd4; stride = 16'd3;
      next(); start = 1'b0; stride = 16'd1;
      wait_idle("t6_timeout", 16'hFFFF);
      chk_seq("t6_addr_rl1", 3, 32'h0, 3, 4);
      chk_seq("t6_addr_rl2", 4, 32'h0, 3, 4);
      chk_seq("t6_beats_rl1", 1, 32'h0, 3, 4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
